// File: rtl/apb_pkg.sv
// Shared definitions for the APB register completer: register map, FSM states, wait field width.
package apb_pkg;

    localparam int unsigned CTRL_OFF  = 32'h00;
    localparam int unsigned ID_OFF    = 32'h04;
    localparam int unsigned SCR0_OFF  = 32'h08;
    localparam int unsigned SCR1_OFF  = 32'h0C;
    localparam int unsigned ACC_OFF   = 32'h10;
    localparam int unsigned CNT_OFF   = 32'h14;
    localparam int unsigned MAP_LIMIT = 32'h18;

    localparam int WAIT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage, read mux and error decode for the APB completer.
// All decode works on the request captured at setup, so live bus changes never leak in.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hA5B0_0001,
    parameter int RESET_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [WAIT_W-1:0] wait_cfg,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic [DATA_W-1:0] ctrl;
    logic [DATA_W-1:0] scr0;
    logic [DATA_W-1:0] scr1;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] cnt;

    assign wait_cfg = ctrl[WAIT_W-1:0];

    // Flag misaligned, out-of-map and read-only-target writes as slave errors.
    always_comb begin
        err = 1'b0;
        if (addr[1:0] != 2'b00) begin
            err = 1'b1;
        end
        if (addr >= ADDR_W'(MAP_LIMIT)) begin
            err = 1'b1;
        end
        if (wr && (addr == ADDR_W'(ID_OFF) || addr == ADDR_W'(CNT_OFF))) begin
            err = 1'b1;
        end
    end

    // Select read data for the captured address; errors always read back as zero.
    always_comb begin
        rdata = '0;
        if (!err) begin
            case (addr)
                ADDR_W'(CTRL_OFF): rdata = ctrl;
                ADDR_W'(ID_OFF):   rdata = ID_VALUE;
                ADDR_W'(SCR0_OFF): rdata = scr0;
                ADDR_W'(SCR1_OFF): rdata = scr1;
                ADDR_W'(ACC_OFF):  rdata = acc;
                ADDR_W'(CNT_OFF):  rdata = cnt;
                default:           rdata = '0;
            endcase
        end
    end

    // Apply writes/accumulate and count good transfers on the completing edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= DATA_W'(WAIT_W'(RESET_WAIT));
            scr0 <= '0;
            scr1 <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (commit && !err) begin
            cnt <= cnt + DATA_W'(1);
            if (wr) begin
                case (addr)
                    ADDR_W'(CTRL_OFF): ctrl <= wdata;
                    ADDR_W'(SCR0_OFF): scr0 <= wdata;
                    ADDR_W'(SCR1_OFF): scr1 <= wdata;
                    ADDR_W'(ACC_OFF):  acc  <= acc + wdata;
                    default:           ;
                endcase
            end
        end
    end

endmodule

// File: rtl/apb_reg_completer.sv
// APB3 completer: captures the request at setup, stretches PREADY by the programmed
// wait count, then completes with data/error from the register bank.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hA5B0_0001,
    parameter int RESET_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_wr;
    logic [WAIT_W-1:0] wcnt;
    logic [WAIT_W-1:0] wait_cfg;
    logic [DATA_W-1:0] bank_rdata;
    logic              bank_err;
    logic              commit;
    logic              setup;

    assign setup = psel && !penable;

    apb_reg_bank #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ID_VALUE   (ID_VALUE),
        .RESET_WAIT (RESET_WAIT)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .commit   (commit),
        .addr     (cap_addr),
        .wr       (cap_wr),
        .wdata    (cap_wdata),
        .wait_cfg (wait_cfg),
        .rdata    (bank_rdata),
        .err      (bank_err)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the request and wait count at setup; count down wait cycles while selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
            wcnt      <= '0;
        end else if (state == IDLE && setup) begin
            cap_addr  <= paddr;
            cap_wdata <= pwdata;
            cap_wr    <= pwrite;
            wcnt      <= wait_cfg;
        end else if (state == ACCESS && psel && wcnt != '0) begin
            wcnt <= wcnt - WAIT_W'(1);
        end
    end

    // Next-state: enter ACCESS on setup, leave on abort or completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || wcnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs come from state, wcnt and the captured request; commit also needs psel still held.
    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        commit  = 1'b0;
        if (state == ACCESS && wcnt == '0) begin
            pready  = 1'b1;
            pslverr = bank_err;
            prdata  = cap_wr ? '0 : bank_rdata;
            commit  = psel;
        end
    end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Self-checking bench for apb_reg_completer: directed scenarios then random traffic
// compared against a register-map reference model.
module tb_apb_reg_completer;

    localparam logic [31:0] ID_VAL = 32'hA5B0_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] m_reg [6];

    apb_reg_completer dut (
        .clk     (clk),
        .rst     (rst),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_reg[0] = 32'h0;
        m_reg[1] = ID_VAL;
        m_reg[2] = 32'h0;
        m_reg[3] = 32'h0;
        m_reg[4] = 32'h0;
        m_reg[5] = 32'h0;
    endtask

    // Register-map rules: word index = addr/4; ID and CNT are read-only.
    task automatic model_step(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                              output logic [31:0] rd, output logic err);
        int idx;
        idx = int'(addr / 4);
        err = (addr % 4 != 0) || (addr >= 32'd24) || (wr && (addr == 32'd4 || addr == 32'd20));
        rd = 32'h0;
        if (!err) begin
            if (!wr) rd = m_reg[idx];
            else if (idx == 4) m_reg[4] = m_reg[4] + wdata;
            else m_reg[idx] = wdata;
            m_reg[5] = m_reg[5] + 1;
        end
    endtask

    // Full transfer; must be entered just after a clock edge. Leaves psel low #1 after completion edge.
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_wait;
        int          waits;
        logic [31:0] got_rd;
        logic        got_err;
        exp_wait = int'(m_reg[0][3:0]);
        model_step(addr, wdata, wr, exp_rd, exp_err);
        paddr = addr; pwdata = wdata; pwrite = wr; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = $urandom; pwdata = $urandom;
        waits = 0;
        while (!pready && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        check("completion", {31'b0, pready}, 32'd1);
        got_rd = prdata;
        got_err = pslverr;
        check("wait_cycles", 32'(waits), 32'(exp_wait));
        check("prdata", got_rd, exp_rd);
        check("pslverr", {31'b0, got_err}, {31'b0, exp_err});
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pready", {31'b0, pready}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        check("reset_pslverr", {31'b0, pslverr}, 32'd0);
        rst = 1'b0;

        // ID read with zero waits, then CNT counts it
        do_xfer(32'h04, 32'h0, 1'b0);
        do_xfer(32'h14, 32'h0, 1'b0);

        // wait states and scratch write/readback
        do_xfer(32'h00, 32'h0000_0003, 1'b1);
        do_xfer(32'h08, 32'h1234_5678, 1'b1);
        do_xfer(32'h08, 32'h0, 1'b0);

        // accumulator wrap
        do_xfer(32'h10, 32'hFFFF_FFF0, 1'b1);
        do_xfer(32'h10, 32'h0000_0020, 1'b1);
        do_xfer(32'h10, 32'h0, 1'b0);

        // error responses, then ID and CNT unaffected
        do_xfer(32'h04, 32'hDEAD_BEEF, 1'b1);
        do_xfer(32'h18, 32'h0, 1'b0);
        do_xfer(32'h09, 32'h0, 1'b0);
        do_xfer(32'h14, 32'h1, 1'b1);
        do_xfer(32'h04, 32'h0, 1'b0);
        do_xfer(32'h14, 32'h0, 1'b0);

        // abort mid-wait with WAIT=5
        do_xfer(32'h00, 32'h0000_0005, 1'b1);
        paddr = 32'h0C; pwdata = 32'hCAFE_F00D; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("abort_wait_pready", {31'b0, pready}, 32'd0);
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_pready", {31'b0, pready}, 32'd0);
        do_xfer(32'h0C, 32'h0, 1'b0);
        do_xfer(32'h14, 32'h0, 1'b0);

        // synchronous reset in the middle of a waited write
        do_xfer(32'h00, 32'h0000_0004, 1'b1);
        paddr = 32'h08; pwdata = 32'h0BAD_0BAD; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_pready", {31'b0, pready}, 32'd0);
        check("midreset_prdata", prdata, 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        do_xfer(32'h00, 32'h0, 1'b0);
        do_xfer(32'h08, 32'h0, 1'b0);

        // randomized traffic against the model
        do_xfer(32'h00, 32'h0000_0001, 1'b1);
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            a = 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 32'h00) d = d & 32'hFFFF_FFF3;
            do_xfer(a, d, w);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
- APB3 completer (responder) holding a small register bank, with programmable wait states and PSLVERR reporting.
- It answers transfers from apb_master, either directly or through apb_async_bridge on the completer clock side.
- Its purpose is to exercise the initiator and bridge handshakes under controlled PREADY stretching and error responses.

Parameters:
- ADDR_W, 32: width of paddr.
- DATA_W, 32: width of pwdata and prdata.
- ID_VALUE, 32'hA5B0_0001: constant returned by the ID register.
- RESET_WAIT, 0: reset value of CTRL[3:0], the number of wait states (0..15).

Ports:
- clk  in  1  completer clock.
- rst  in  1  synchronous, active-high reset.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- pwrite  in  1  1 = write, 0 = read.
- psel  in  1  select.
- penable  in  1  access phase.
- pready  out  1  transfer complete.
- prdata  out  DATA_W  read data; valid only when pready=1 and the transfer is a read.
- pslverr  out  1  error response; valid only when pready=1.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE, pready=0, pslverr=0, prdata=0.
  - CTRL = {28'b0, RESET_WAIT[3:0]}; SCR0 = SCR1 = ACC = CNT = 0.
  - Reset mid-transfer aborts the transfer with no register update.
- Register map (byte offsets):
  - 0x00 CTRL: RW, all 32 bits stored; bits [3:0] = WAIT.
  - 0x04 ID: RO, reads ID_VALUE.
  - 0x08 SCR0: RW.
  - 0x0C SCR1: RW.
  - 0x10 ACC: a write adds pwdata modulo 2^32 (wraps, no carry out); a read returns the current sum.
  - 0x14 CNT: RO; counts completed non-error transfers, wraps 0xFFFF_FFFF to 0.
- Errors (pslverr=1 at completion):
  - paddr[1:0] != 0.
  - paddr >= 0x18.
  - Write to ID or CNT.
  - An erroring transfer updates no register and does not increment CNT. Read data on an error is 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - When psel=1 and penable=0 (setup phase), capture paddr, pwrite and pwdata into local registers, load wcnt = CTRL[3:0], go to ACCESS.
  - Anything else stays in IDLE.
- ACCESS:
  - If psel=0, abort: return to IDLE, no commit, no count.
  - Else if wcnt != 0: wcnt--, pready=0.
  - Else (wcnt == 0): pready=1 and pslverr/prdata are driven from the captured request. On that edge, commit the write or ACC add, increment CNT if there is no error, and go to IDLE.
- Outputs:
  - pready and pslverr are decoded only from state, wcnt and the captured request, never from live bus inputs.
  - prdata is 0 whenever pready=0 or the transfer is a write.
- Latency: the transfer occupies WAIT+2 clk cycles (setup + WAIT wait cycles + 1 completing access cycle). WAIT=0 gives a zero-wait APB transfer.
- Back-to-back: a new setup phase in the cycle right after completion is accepted from IDLE with no bubble.
- Writing CTRL changes WAIT starting with the next transfer; the current transfer keeps its latched wcnt.
- CNT read value is the count before the read itself; the read then increments CNT.
- paddr and pwdata changes during ACCESS are ignored because the values are captured at setup.

Decomposition:
- Shared package apb_pkg holds:
  - Register offset localparams: CTRL_OFF, ID_OFF, SCR0_OFF, SCR1_OFF, ACC_OFF, CNT_OFF, MAP_LIMIT=0x18.
  - State encoding for IDLE/ACCESS.
  - The WAIT field width (4).
- One sub-module, apb_reg_bank, contains the register storage, the read mux and the error decode. It takes a commit strobe plus the captured addr/wr/wdata, and returns rdata/err.
- The FSM and wait counter stay in apb_reg_completer.

Test Plan:
- Reset, then read 0x04 with WAIT=0 -> pready on the 2nd cycle, prdata=0xA5B0_0001, pslverr=0; a subsequent read of CNT returns 1.
- Write 0x0000_0003 to CTRL, then write 0x1234_5678 to SCR0 -> the SCR0 write completes with pready low for exactly 3 access cycles; reading SCR0 back returns 0x1234_5678.
- Write 0xFFFF_FFF0 then 0x0000_0020 to ACC -> reading ACC returns 0x0000_0010 (wrap).
- Write to 0x04, read 0x18, read 0x09 -> each gives pslverr=1 with prdata=0; the ID value is unchanged and CNT does not advance.
- Deassert psel during ACCESS with WAIT=5 on a SCR1 write -> no pready, SCR1 stays 0, CNT unchanged; the next transfer completes normally.
- Assert rst for one cycle mid-wait -> pready=0 and CTRL[3:0]=RESET_WAIT afterwards; the pending write is discarded.
